// File: rtl/zone_target_tracker.sv
// Per-frame target pixel counter over NUM_ZONES vertical strips, with argmax zone selection
// and frame-to-frame hysteresis on the detect flag.
module zone_target_tracker #(
   parameter int unsigned H_ACTIVE   = 640,
   parameter int unsigned NUM_ZONES  = 5,
   parameter int unsigned MIN_PIXELS = 200,
   parameter int unsigned PERSIST    = 3,
   parameter int unsigned CNT_W      = 19
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         active,
   input  logic                         vsync_n,
   input  logic                         is_target,
   output logic [$clog2(NUM_ZONES)-1:0] zone_idx,
   output logic                         detected,
   output logic                         result_valid,
   output logic [CNT_W-1:0]             total_count,
   output logic                         frame_overrun
);

   localparam int unsigned ZW        = $clog2(NUM_ZONES);
   localparam int unsigned CW        = $clog2(H_ACTIVE);
   localparam int unsigned PW        = $clog2(PERSIST + 1);
   localparam int unsigned ZONE_COLS = H_ACTIVE / NUM_ZONES;

   typedef enum logic [1:0] {StAccum, StSnap, StScan, StPublish} state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    col_q;
   logic             vs_q, armed_q, fall_q;
   logic [CNT_W-1:0] zone_cnt_q [NUM_ZONES];
   logic [CNT_W-1:0] shadow_q   [NUM_ZONES];
   logic [CNT_W-1:0] total_q, shadow_total_q, best_val_q;
   logic [ZW-1:0]    scan_idx_q, best_idx_q, zone_idx_q;
   logic [CNT_W-1:0] total_count_q;
   logic [PW-1:0]    hit_q, miss_q;
   logic             detected_q;

   logic [CW-1:0]    col_zone;
   logic [ZW-1:0]    pix_zone, final_idx;
   logic [CNT_W-1:0] scan_val;
   logic [PW-1:0]    hit_inc, miss_inc;
   logic             pix, take, scan_last, hit;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == '1) ? v : v + CNT_W'(1);
   endfunction

   // Remainder columns beyond NUM_ZONES*ZONE_COLS fold into the last zone.
   assign col_zone  = col_q / CW'(ZONE_COLS);
   assign pix_zone  = (col_zone >= CW'(NUM_ZONES - 1)) ? ZW'(NUM_ZONES - 1) : col_zone[ZW-1:0];
   assign pix       = active & is_target;

   assign scan_val  = shadow_q[scan_idx_q];
   assign take      = (scan_idx_q == '0) || (scan_val > best_val_q);
   assign final_idx = take ? scan_idx_q : best_idx_q;
   assign scan_last = (scan_idx_q == ZW'(NUM_ZONES - 1));
   assign hit       = (shadow_total_q >= CNT_W'(MIN_PIXELS));
   assign hit_inc   = (hit_q == PW'(PERSIST)) ? hit_q : hit_q + PW'(1);
   assign miss_inc  = (miss_q == PW'(PERSIST)) ? miss_q : miss_q + PW'(1);

   always_comb begin
      state_d = state_q;
      case (state_q)
         StAccum:   if (fall_q) state_d = StSnap;
         StSnap:    state_d = StScan;
         StScan:    if (scan_last) state_d = StPublish;
         StPublish: state_d = StAccum;
         default:   state_d = StAccum;
      endcase
   end

   assign result_valid  = (state_q == StPublish);
   assign frame_overrun = fall_q && (state_q != StAccum);
   assign zone_idx      = zone_idx_q;
   assign detected      = detected_q;
   assign total_count   = total_count_q;

   // armed_q masks the first cycle after reset so a low vsync_n at release is not an edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StAccum;
         col_q   <= '0;
         vs_q    <= 1'b1;
         armed_q <= 1'b0;
         fall_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         col_q   <= (!active || col_q == CW'(H_ACTIVE - 1)) ? '0 : col_q + CW'(1);
         vs_q    <= vsync_n;
         armed_q <= 1'b1;
         fall_q  <= armed_q & vs_q & ~vsync_n;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned z = 0; z < NUM_ZONES; z++) begin
            zone_cnt_q[z] <= '0;
            shadow_q[z]   <= '0;
         end
         total_q        <= '0;
         shadow_total_q <= '0;
      end else if (state_q == StSnap) begin
         for (int unsigned z = 0; z < NUM_ZONES; z++) begin
            shadow_q[z]   <= zone_cnt_q[z];
            zone_cnt_q[z] <= (pix && pix_zone == ZW'(z)) ? CNT_W'(1) : '0;
         end
         shadow_total_q <= total_q;
         total_q        <= pix ? CNT_W'(1) : '0;
      end else if (pix) begin
         for (int unsigned z = 0; z < NUM_ZONES; z++) begin
            if (pix_zone == ZW'(z)) zone_cnt_q[z] <= sat_inc(zone_cnt_q[z]);
         end
         total_q <= sat_inc(total_q);
      end
   end

   // Results commit on the last scan cycle so they are already visible during the pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scan_idx_q    <= '0;
         best_idx_q    <= '0;
         best_val_q    <= '0;
         zone_idx_q    <= ZW'(NUM_ZONES / 2);
         total_count_q <= '0;
         hit_q         <= '0;
         miss_q        <= '0;
         detected_q    <= 1'b0;
      end else if (state_q == StSnap) begin
         scan_idx_q <= '0;
      end else if (state_q == StScan) begin
         scan_idx_q <= scan_idx_q + ZW'(1);
         if (take) begin
            best_val_q <= scan_val;
            best_idx_q <= scan_idx_q;
         end
         if (scan_last) begin
            total_count_q <= shadow_total_q;
            if (hit) begin
               zone_idx_q <= final_idx;
               miss_q     <= '0;
               hit_q      <= hit_inc;
               if (hit_inc == PW'(PERSIST)) detected_q <= 1'b1;
            end else begin
               hit_q  <= '0;
               miss_q <= miss_inc;
               if (miss_inc == PW'(PERSIST)) detected_q <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_zone_target_tracker.sv
// Directed bench for zone_target_tracker; a second narrow-counter instance covers saturation.
module tb_zone_target_tracker;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        active = 1'b0;
   logic        vsync_n = 1'b1;
   logic        is_target = 1'b0;
   logic [2:0]  zone_idx, sat_zone_idx;
   logic        detected, result_valid, frame_overrun;
   logic        sat_detected, sat_result_valid, sat_frame_overrun;
   logic [18:0] total_count;
   logic [9:0]  sat_total_count;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   zone_target_tracker u_dut (
      .clk(clk), .rst_n(rst_n), .active(active), .vsync_n(vsync_n), .is_target(is_target),
      .zone_idx(zone_idx), .detected(detected), .result_valid(result_valid),
      .total_count(total_count), .frame_overrun(frame_overrun)
   );

   zone_target_tracker #(.CNT_W(10)) u_sat (
      .clk(clk), .rst_n(rst_n), .active(active), .vsync_n(vsync_n), .is_target(is_target),
      .zone_idx(sat_zone_idx), .detected(sat_detected), .result_valid(sat_result_valid),
      .total_count(sat_total_count), .frame_overrun(sat_frame_overrun)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // One active line with targets on columns [first, first+n).
   task automatic line(input int first, input int n);
      for (int c = 0; c < 640; c++) begin
         @(negedge clk);
         active    = 1'b1;
         is_target = (c >= first) && (c < first + n);
      end
      @(negedge clk);
      active    = 1'b0;
      is_target = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   // Returns at the negedge where result_valid is seen high.
   task automatic frame_end(input string tag);
      int lat;
      bit seen;
      @(negedge clk);
      vsync_n = 1'b0;
      lat = 0;
      seen = 1'b0;
      while (!seen && lat < 40) begin
         @(negedge clk);
         vsync_n = 1'b1;
         lat++;
         if (result_valid) seen = 1'b1;
      end
      chk({tag, " latency"}, lat, 8);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int rv;
      int ov;

      // Reset values, with vsync_n held low across release.
      vsync_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst zone_idx", zone_idx, 2);
      chk("rst detected", detected, 0);
      chk("rst result_valid", result_valid, 0);
      chk("rst total_count", total_count, 0);
      chk("rst frame_overrun", frame_overrun, 0);
      rst_n = 1'b1;
      rv = 0;
      repeat (20) begin
         @(negedge clk);
         if (result_valid) rv++;
      end
      chk("no pulse after release", rv, 0);
      vsync_n = 1'b1;
      repeat (3) @(negedge clk);

      // 300 targets: zones 0,1 tie at 128.
      line(0, 300);
      frame_end("t2");
      chk("t2 total", total_count, 300);
      chk("t2 zone tie", zone_idx, 0);
      chk("t2 detected", detected, 0);

      frame_end("empty");
      chk("empty total", total_count, 0);
      chk("empty zone hold", zone_idx, 0);

      for (int f = 1; f <= 3; f++) begin
         line(512, 125);
         line(512, 125);
         frame_end($sformatf("t3 hit%0d", f));
         chk($sformatf("t3 hit%0d total", f), total_count, 250);
         chk($sformatf("t3 hit%0d zone", f), zone_idx, 4);
         chk($sformatf("t3 hit%0d detected", f), detected, (f == 3) ? 1 : 0);
      end
      for (int f = 1; f <= 2; f++) begin
         line(512, 50);
         frame_end($sformatf("t3 miss%0d", f));
         chk($sformatf("t3 miss%0d total", f), total_count, 50);
         chk($sformatf("t3 miss%0d detected", f), detected, 1);
      end
      line(512, 125);
      line(512, 125);
      frame_end("t3 rehit");
      chk("t3 rehit detected", detected, 1);

      for (int f = 1; f <= 3; f++) begin
         line(512, 100);
         frame_end($sformatf("t4 miss%0d", f));
         chk($sformatf("t4 miss%0d total", f), total_count, 100);
         chk($sformatf("t4 miss%0d zone", f), zone_idx, 4);
         chk($sformatf("t4 miss%0d detected", f), detected, (f == 3) ? 0 : 1);
      end

      // 1034 continuous target pixels: exact on 19 bits, saturated on 10 bits.
      @(negedge clk);
      active    = 1'b1;
      is_target = 1'b1;
      repeat (1034) @(negedge clk);
      active    = 1'b0;
      is_target = 1'b0;
      repeat (3) @(negedge clk);
      frame_end("t5");
      chk("t5 total", total_count, 1034);
      chk("t5 zone", zone_idx, 0);
      chk("t5 sat valid", sat_result_valid, 1);
      chk("t5 sat total", sat_total_count, 1023);

      // Two frame ends 3 cycles apart.
      rv = 0;
      ov = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (result_valid) rv++;
         if (frame_overrun) ov++;
         vsync_n = !(i == 0 || i == 3);
      end
      chk("t6 result_valid count", rv, 1);
      chk("t6 overrun count", ov, 1);
      chk("t6 zone hold", zone_idx, 0);

      // Reset while scanning.
      @(negedge clk);
      vsync_n = 1'b0;
      @(negedge clk);
      vsync_n = 1'b1;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("t6 midscan zone_idx", zone_idx, 2);
      chk("t6 midscan result_valid", result_valid, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      rv = 0;
      repeat (20) begin
         @(negedge clk);
         if (result_valid) rv++;
      end
      chk("t6 no result after reset", rv, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
